// File: rtl/pixel_write_arbiter_pkg.sv
// Shared colour definitions for the pixel write path.
// The framebuffer blocks and drawing tools all use these.
package pixel_write_arbiter_pkg;

    localparam int COLOR_WIDTH = 8;

    typedef logic [COLOR_WIDTH-1:0] color_t;

    // COLOR_NONE is the "transparent" sentinel: requests carrying it are consumed but never drawn.
    localparam color_t COLOR_NONE  = 8'h00;
    localparam color_t COLOR_RED   = 8'hE0;
    localparam color_t COLOR_GREEN = 8'h1C;
    localparam color_t COLOR_BLUE  = 8'h03;
    localparam color_t COLOR_WHITE = 8'hFF;

    function automatic logic color_is_drawable(input color_t c);
        return c != COLOR_NONE;
    endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_select.sv
// Combinational round-robin picker: one-hot grant to the first active request
// found after last_grant, wrapping around.
module rr_select #(
    parameter int N  = 3,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    int  idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Arbitrates several drawing tools onto one framebuffer write port and
// performs full-screen fills that lock the tools out until done.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int N      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N-1:0]                    req_valid,
    input  logic [N*$clog2(WIDTH)-1:0]      req_x,
    input  logic [N*$clog2(HEIGHT)-1:0]     req_y,
    input  logic [N*COLOR_WIDTH-1:0]        req_color,
    output logic [N-1:0]                    req_ready,
    input  logic                            clear_start,
    input  logic [COLOR_WIDTH-1:0]          clear_color,
    output logic                            clear_busy,
    output logic                            wr_en,
    output logic [$clog2(WIDTH)-1:0]        wr_x,
    output logic [$clog2(HEIGHT)-1:0]       wr_y,
    output logic [COLOR_WIDTH-1:0]          wr_color
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_ARB, S_CLEAR} state_t;

    state_t                 state;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          grant_idx;
    logic [N-1:0]           grant;
    logic                   transfer;
    logic [XW-1:0]          sel_x;
    logic [YW-1:0]          sel_y;
    color_t                 sel_color;
    logic [XW-1:0]          sweep_x;
    logic [YW-1:0]          sweep_y;
    logic [XW-1:0]          next_x;
    logic [YW-1:0]          next_y;
    logic                   row_end;
    logic                   sweep_done;
    color_t                 fill_color;

    rr_select #(
        .N  (N),
        .GW (GW)
    ) u_rr_select (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // A fill request takes priority over the tools in the cycle it arrives.
    assign req_ready = (state == S_ARB && !reset && !clear_start) ? grant : '0;
    assign transfer  = |req_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = GW'(i);
        end
    end

    assign sel_x     = req_x[grant_idx*XW +: XW];
    assign sel_y     = req_y[grant_idx*YW +: YW];
    assign sel_color = req_color[grant_idx*COLOR_WIDTH +: COLOR_WIDTH];

    assign row_end    = (sweep_x == XW'(WIDTH - 1));
    assign sweep_done = row_end && (sweep_y == YW'(HEIGHT - 1));
    assign next_x     = row_end ? '0 : sweep_x + 1'b1;
    assign next_y     = row_end ? sweep_y + 1'b1 : sweep_y;

    // The sweep counters always hold the pixel currently presented on wr_*;
    // pixel (0,0) is loaded on the start cycle so wr_en lines up with clear_busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ARB;
            last_grant <= GW'(N - 1);
            sweep_x    <= '0;
            sweep_y    <= '0;
            fill_color <= COLOR_NONE;
            clear_busy <= 1'b0;
            wr_en      <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_color   <= COLOR_NONE;
        end else begin
            case (state)
                S_ARB: begin
                    if (clear_start) begin
                        state      <= S_CLEAR;
                        fill_color <= clear_color;
                        clear_busy <= 1'b1;
                        sweep_x    <= '0;
                        sweep_y    <= '0;
                        wr_en      <= 1'b1;
                        wr_x       <= '0;
                        wr_y       <= '0;
                        wr_color   <= clear_color;
                    end else if (transfer) begin
                        last_grant <= grant_idx;
                        wr_en      <= color_is_drawable(sel_color);
                        if (color_is_drawable(sel_color)) begin
                            wr_x     <= sel_x;
                            wr_y     <= sel_y;
                            wr_color <= sel_color;
                        end
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (sweep_done) begin
                        state      <= S_ARB;
                        clear_busy <= 1'b0;
                        wr_en      <= 1'b0;
                        sweep_x    <= '0;
                        sweep_y    <= '0;
                    end else begin
                        sweep_x  <= next_x;
                        sweep_y  <= next_y;
                        wr_en    <= 1'b1;
                        wr_x     <= next_x;
                        wr_y     <= next_y;
                        wr_color <= fill_color;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter on an 8x8 screen with three tools:
// fixed vector table, fill/reset sequences, then randomized traffic against a model.
module tb_pixel_write_arbiter;
    import pixel_write_arbiter_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = 3;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int CW = COLOR_WIDTH;

    localparam logic [N*XW-1:0] FIX_X = {3'd5, 3'd3, 3'd1};
    localparam logic [N*YW-1:0] FIX_Y = {3'd6, 3'd4, 3'd2};
    localparam logic [N*CW-1:0] ALL_C = {COLOR_GREEN, COLOR_BLUE, COLOR_RED};
    localparam logic [N*CW-1:0] NONE0 = {COLOR_GREEN, COLOR_BLUE, COLOR_NONE};

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*XW-1:0]   req_x;
    logic [N*YW-1:0]   req_y;
    logic [N*CW-1:0]   req_color;
    logic [N-1:0]      req_ready;
    logic              clear_start;
    logic [CW-1:0]     clear_color;
    logic              clear_busy;
    logic              wr_en;
    logic [XW-1:0]     wr_x;
    logic [YW-1:0]     wr_y;
    logic [CW-1:0]     wr_color;

    int checks = 0;
    int errors = 0;

    pixel_write_arbiter #(.WIDTH(W), .HEIGHT(H), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*CW-1:0] colors;
        logic [N-1:0]    exp_ready;
        logic            exp_en;
        logic [XW-1:0]   exp_x;
        logic [YW-1:0]   exp_y;
        logic [CW-1:0]   exp_color;
    } vec_t;

    vec_t tbl[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*CW-1:0] cs,
                                 input logic cstart, input logic [CW-1:0] ccol);
        req_valid   = v;
        req_color   = cs;
        clear_start = cstart;
        clear_color = ccol;
    endtask

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int lg);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (lg + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        int mlg;
        int p;
        logic           exp_en;
        logic [XW-1:0]  ex;
        logic [YW-1:0]  ey;
        logic [CW-1:0]  ec;
        logic [N-1:0]   v;
        logic [N*XW-1:0] rx;
        logic [N*YW-1:0] ry;
        logic [N*CW-1:0] rc;
        logic [CW-1:0]  c;

        tbl[0]  = '{3'b111, ALL_C, 3'b001, 1'b1, 3'd1, 3'd2, COLOR_RED};
        tbl[1]  = '{3'b111, ALL_C, 3'b010, 1'b1, 3'd3, 3'd4, COLOR_BLUE};
        tbl[2]  = '{3'b111, ALL_C, 3'b100, 1'b1, 3'd5, 3'd6, COLOR_GREEN};
        tbl[3]  = '{3'b111, ALL_C, 3'b001, 1'b1, 3'd1, 3'd2, COLOR_RED};
        tbl[4]  = '{3'b111, ALL_C, 3'b010, 1'b1, 3'd3, 3'd4, COLOR_BLUE};
        tbl[5]  = '{3'b111, ALL_C, 3'b100, 1'b1, 3'd5, 3'd6, COLOR_GREEN};
        tbl[6]  = '{3'b010, ALL_C, 3'b010, 1'b1, 3'd3, 3'd4, COLOR_BLUE};
        tbl[7]  = '{3'b010, ALL_C, 3'b010, 1'b1, 3'd3, 3'd4, COLOR_BLUE};
        tbl[8]  = '{3'b000, ALL_C, 3'b000, 1'b0, 3'd3, 3'd4, COLOR_BLUE};
        tbl[9]  = '{3'b001, NONE0, 3'b001, 1'b0, 3'd3, 3'd4, COLOR_BLUE};
        tbl[10] = '{3'b101, ALL_C, 3'b100, 1'b1, 3'd5, 3'd6, COLOR_GREEN};
        tbl[11] = '{3'b011, ALL_C, 3'b001, 1'b1, 3'd1, 3'd2, COLOR_RED};
        tbl[12] = '{3'b110, ALL_C, 3'b010, 1'b1, 3'd3, 3'd4, COLOR_BLUE};

        reset = 1'b1;
        req_x = FIX_X;
        req_y = FIX_Y;
        applyStimulus(3'b000, ALL_C, 1'b0, COLOR_NONE);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset_wr_x", 32'(wr_x), 32'd0);
        checkOutput("reset_wr_y", 32'(wr_y), 32'd0);
        checkOutput("reset_wr_color", 32'(wr_color), 32'(COLOR_NONE));
        checkOutput("reset_busy", 32'(clear_busy), 32'd0);
        applyStimulus(3'b111, ALL_C, 1'b0, COLOR_NONE);
        #4;
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].colors, 1'b0, COLOR_NONE);
            #4;
            checkOutput($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].exp_en));
            checkOutput($sformatf("tbl%0d_wr_x", i), 32'(wr_x), 32'(tbl[i].exp_x));
            checkOutput($sformatf("tbl%0d_wr_y", i), 32'(wr_y), 32'(tbl[i].exp_y));
            checkOutput($sformatf("tbl%0d_wr_color", i), 32'(wr_color), 32'(tbl[i].exp_color));
        end

        // Fill in green with every tool asking; a restart attempt at pixel 10 must be ignored.
        applyStimulus(3'b111, ALL_C, 1'b1, COLOR_GREEN);
        #4;
        checkOutput("clear_start_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < W * H; k++) begin
            checkOutput($sformatf("sweep%0d_wr_en", k), 32'(wr_en), 32'd1);
            checkOutput($sformatf("sweep%0d_wr_x", k), 32'(wr_x), 32'(k % W));
            checkOutput($sformatf("sweep%0d_wr_y", k), 32'(wr_y), 32'(k / W));
            checkOutput($sformatf("sweep%0d_color", k), 32'(wr_color), 32'(COLOR_GREEN));
            checkOutput($sformatf("sweep%0d_busy", k), 32'(clear_busy), 32'd1);
            applyStimulus(3'b111, ALL_C, (k == 10), (k == 10) ? COLOR_RED : COLOR_GREEN);
            #4;
            checkOutput($sformatf("sweep%0d_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("sweep_end_busy", 32'(clear_busy), 32'd0);
        checkOutput("sweep_end_wr_en", 32'(wr_en), 32'd0);
        checkOutput("sweep_end_wr_x", 32'(wr_x), 32'd7);
        checkOutput("sweep_end_wr_y", 32'(wr_y), 32'd7);
        applyStimulus(3'b111, ALL_C, 1'b0, COLOR_NONE);
        #4;
        checkOutput("after_sweep_ready", 32'(req_ready), 32'b100);
        @(posedge clk);
        #1;
        checkOutput("after_sweep_wr_en", 32'(wr_en), 32'd1);
        checkOutput("after_sweep_wr_x", 32'(wr_x), 32'd5);
        checkOutput("after_sweep_wr_y", 32'(wr_y), 32'd6);
        checkOutput("after_sweep_color", 32'(wr_color), 32'(COLOR_GREEN));

        // Reset lands while pixel 20 is on the port: the sweep must stop dead.
        applyStimulus(3'b111, ALL_C, 1'b1, COLOR_WHITE);
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(3'b111, ALL_C, 1'b0, COLOR_WHITE);
            #4;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_pixel20_x", 32'(wr_x), 32'd4);
        checkOutput("abort_pixel20_y", 32'(wr_y), 32'd2);
        checkOutput("abort_pixel20_color", 32'(wr_color), 32'(COLOR_WHITE));
        reset = 1'b1;
        #4;
        checkOutput("abort_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
        checkOutput("abort_busy", 32'(clear_busy), 32'd0);
        checkOutput("abort_wr_x", 32'(wr_x), 32'd0);
        checkOutput("abort_wr_color", 32'(wr_color), 32'(COLOR_NONE));
        reset = 1'b0;
        #4;
        checkOutput("abort_next_ready", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        checkOutput("abort_next_wr_en", 32'(wr_en), 32'd1);
        checkOutput("abort_next_wr_x", 32'(wr_x), 32'd1);
        checkOutput("abort_next_color", 32'(wr_color), 32'(COLOR_RED));
        applyStimulus(3'b000, ALL_C, 1'b0, COLOR_NONE);
        for (int k = 0; k < 3; k++) begin
            #4;
            @(posedge clk);
            #1;
            checkOutput($sformatf("abort_idle%0d_wr_en", k), 32'(wr_en), 32'd0);
            checkOutput($sformatf("abort_idle%0d_busy", k), 32'(clear_busy), 32'd0);
        end

        // Random traffic: model tracks last winner and the write it should produce.
        mlg = 0;
        for (int n = 0; n < 300; n++) begin
            v = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                rx[i*XW +: XW] = XW'($urandom_range(0, W - 1));
                ry[i*YW +: YW] = YW'($urandom_range(0, H - 1));
                case ($urandom_range(0, 4))
                    0:       c = COLOR_NONE;
                    1:       c = COLOR_RED;
                    2:       c = COLOR_GREEN;
                    3:       c = COLOR_BLUE;
                    default: c = CW'($urandom);
                endcase
                rc[i*CW +: CW] = c;
            end
            req_x = rx;
            req_y = ry;
            applyStimulus(v, rc, 1'b0, COLOR_NONE);
            p = pick(v, mlg);
            #4;
            checkOutput($sformatf("rnd%0d_ready", n), 32'(req_ready), (p < 0) ? 32'd0 : (32'd1 << p));
            exp_en = 1'b0;
            ex = '0;
            ey = '0;
            ec = COLOR_NONE;
            if (p >= 0) begin
                mlg = p;
                ec  = rc[p*CW +: CW];
                ex  = rx[p*XW +: XW];
                ey  = ry[p*YW +: YW];
                exp_en = (ec != COLOR_NONE);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d_wr_en", n), 32'(wr_en), 32'(exp_en));
            if (exp_en) begin
                checkOutput($sformatf("rnd%0d_wr_x", n), 32'(wr_x), 32'(ex));
                checkOutput($sformatf("rnd%0d_wr_y", n), 32'(wr_y), 32'(ey));
                checkOutput($sformatf("rnd%0d_wr_color", n), 32'(wr_color), 32'(ec));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 640, screen width in pixels.
REQ-002 Parameter HEIGHT, default 480, screen height in pixels.
REQ-003 Parameter N, default 3, number of pixel requesters (drawing tools).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N  requester i offers a pixel.
REQ-007 req_x  input  N x $clog2(WIDTH)  requester pixel x.
REQ-008 req_y  input  N x $clog2(HEIGHT)  requester pixel y.
REQ-009 req_color  input  N x COLOR_WIDTH  requester pixel color.
REQ-010 req_ready  output  N  one-hot or zero; requester i accepted this cycle when valid and ready.
REQ-011 clear_start  input  1  pulse to start a full-screen fill.
REQ-012 clear_color  input  COLOR_WIDTH  fill color, sampled with clear_start.
REQ-013 clear_busy  output  1  high while a fill sweep is in progress.
REQ-014 wr_en  output  1  framebuffer write strobe.
REQ-015 wr_x, wr_y, wr_color  output  $clog2(WIDTH), $clog2(HEIGHT), COLOR_WIDTH  framebuffer write address and data.

Function
REQ-016 Two states SHALL exist: S_ARB (arbitrate requesters) and S_CLEAR (fill sweep).
REQ-017 In S_ARB, req_ready SHALL be combinational: grant the first requester with req_valid=1 scanning from (last_grant+1) mod N upward, wrapping.
REQ-018 A transfer on requester i SHALL update last_grant to i; with no transfer last_grant SHALL hold.
REQ-019 At most one req_ready bit SHALL be high per cycle; none high when no req_valid is high.
REQ-020 A transfer SHALL produce, on the next cycle, wr_en=1 with wr_x/wr_y/wr_color equal to the granted requester's values (latency 1, registered outputs).
REQ-021 A transfer whose color equals COLOR_NONE SHALL be accepted (ready high) but SHALL produce wr_en=0.
REQ-022 Cycles without transfer or sweep pixel SHALL drive wr_en=0; wr_x/wr_y/wr_color then hold their last values.
REQ-023 clear_start=1 in S_ARB SHALL force req_ready=0 that cycle, latch clear_color, and enter S_CLEAR next cycle.
REQ-024 In S_CLEAR, one pixel per cycle SHALL be written, x incrementing 0..WIDTH-1 innermost, y 0..HEIGHT-1 outer, wr_en=1 for each, starting at (0,0).
REQ-025 The sweep SHALL take exactly WIDTH*HEIGHT cycles; after writing (WIDTH-1,HEIGHT-1) the state SHALL return to S_ARB next cycle.
REQ-026 clear_busy SHALL be high exactly during S_CLEAR cycles; req_ready SHALL be all zero during S_CLEAR.
REQ-027 clear_start during S_CLEAR SHALL be ignored (no restart, latched color unchanged).
REQ-028 Sweep pixels SHALL be written even when the latched color is COLOR_NONE.
REQ-029 Counter arithmetic SHALL use the port widths; x SHALL wrap to 0 at WIDTH-1, never reaching WIDTH.
REQ-030 last_grant SHALL be unchanged by a sweep.

Reset
REQ-031 reset SHALL set state S_ARB, last_grant=N-1 (requester 0 first), sweep counters 0, wr_en=0, wr_x=0, wr_y=0, wr_color=COLOR_NONE, clear_busy=0.
REQ-032 reset asserted mid-sweep SHALL abort the sweep; no further sweep writes occur.
REQ-033 req_ready SHALL be all zero during reset cycles.

Structure
REQ-034 COLOR_WIDTH, COLOR_NONE and color constants SHALL come from the shared common package; the state enum SHALL be local to the module.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_select (inputs: request vector, last_grant; output: one-hot grant).

Verification (WIDTH=8, HEIGHT=8, N=3)
REQ-036 All req_valid=1 for 6 cycles after reset -> grants 0,1,2,0,1,2; wr_en=1 each following cycle with matching coordinates.
REQ-037 Only requester 1 valid, (3,4,COLOR_BLUE) -> req_ready=3'b010 every cycle; wr_x=3, wr_y=4, wr_color=COLOR_BLUE one cycle later.
REQ-038 Requester 0 valid with COLOR_NONE -> req_ready[0]=1, wr_en=0 next cycle.
REQ-039 clear_start with COLOR_GREEN while all requesters valid -> req_ready=0 that cycle; 64 consecutive wr_en=1 cycles covering (0,0)..(7,7) row-major in GREEN; clear_busy high 64 cycles; arbitration resumes with order unchanged.
REQ-040 Second clear_start at sweep pixel 10 -> ignored; sweep still ends after 64 pixels.
REQ-041 reset at sweep pixel 20 -> wr_en=0, clear_busy=0, next grant to requester 0.
